// File: rtl/usb_unstuff_deser_if.sv
// Bus bundle for usb_unstuff_deser: the decoded bit stream going in and the
// framed word queue coming out.
//
// Handshake: a beat transfers on every rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the head fields
// (out_word/out_nbits/out_last/out_err) hold steady. The input side has no
// backpressure: every cycle with in_valid=1 delivers one bit.
interface usb_unstuff_deser_if #(
    parameter int WORD_W = 8,
    parameter int NB_W   = $clog2(WORD_W + 1)
);
    logic              in_bit;
    logic              in_valid;
    logic              in_eop;
    logic [WORD_W-1:0] out_word;
    logic [NB_W-1:0]   out_nbits;
    logic              out_last;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;
    logic              stuff_err;
    logic              overrun;

    // Upstream side: NRZI decoder feeding bits, consumer accepting words.
    modport master (
        output in_bit, in_valid, in_eop, out_ready,
        input  out_word, out_nbits, out_last, out_err, out_valid,
               stuff_err, overrun
    );

    // Block side: the unstuffer/deserialiser itself.
    modport slave (
        input  in_bit, in_valid, in_eop, out_ready,
        output out_word, out_nbits, out_last, out_err, out_valid,
               stuff_err, overrun
    );
endinterface

// File: rtl/usb_unstuff_deser.sv
// USB receive-path bit unstuffer and LSB-first word deserialiser.
// Drops the bit that follows RUN_LEN consecutive ones (flagging it if it was
// a 1), packs data bits into WORD_W-bit words, frames packets on in_eop and
// hands beats to a 2-entry ready/valid queue that reports overruns.
module usb_unstuff_deser #(
    parameter int RUN_LEN = 6,
    parameter int WORD_W  = 8,
    parameter int NB_W    = $clog2(WORD_W + 1)
) (
    input logic clk,
    input logic nRST,
    usb_unstuff_deser_if.slave bus
);
    localparam int RW = $clog2(RUN_LEN + 1);

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [NB_W-1:0]   nbits;
        logic              last;
        logic              err;
    } beat_t;

    // Bit-level state
    logic [RW-1:0]     run_q, run_d;
    logic              drop_q, drop_d;
    logic [WORD_W-1:0] sh_q, sh_d, sh_bit;
    logic [NB_W-1:0]   cnt_q, cnt_d;
    logic              sticky_q, sticky_d;

    // Queue state
    beat_t             mem_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        level_q, level_d;
    logic              stuff_err_q, overrun_q;

    // Per-cycle events
    logic              stuff_hit, word_done;
    logic              push_a, push_b, acc_a, acc_b, drop_a, drop_b, pop;
    logic [1:0]        free_slots, free_after_a;
    beat_t             beat_a, beat_b, head;

    // Bit processing, beat formation and queue admission for this cycle.
    always_comb begin
        run_d     = run_q;
        drop_d    = drop_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        sh_bit    = sh_q;
        stuff_hit = 1'b0;
        word_done = 1'b0;

        if (bus.in_valid) begin
            if (drop_q) begin
                // Stuffed position: discard, a 1 here is a violation.
                run_d     = '0;
                drop_d    = 1'b0;
                stuff_hit = bus.in_bit;
            end else begin
                sh_bit = sh_q | (WORD_W'(bus.in_bit) << cnt_q);
                if (bus.in_bit) begin
                    run_d = run_q + RW'(1);
                    if (run_q + RW'(1) == RW'(RUN_LEN))
                        drop_d = 1'b1;
                end else begin
                    run_d = '0;
                end
                if (cnt_q == NB_W'(WORD_W - 1)) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
                    sh_d      = '0;
                end else begin
                    cnt_d = cnt_q + NB_W'(1);
                    sh_d  = sh_bit;
                end
            end
        end

        // Queue admission: full word first, then the EOP beat.
        pop          = (level_q != 2'd0) && bus.out_ready;
        free_slots   = 2'd2 - level_q + {1'b0, pop};
        push_a       = word_done;
        push_b       = bus.in_eop;
        acc_a        = push_a && (free_slots != 2'd0);
        drop_a       = push_a && !acc_a;
        free_after_a = free_slots - {1'b0, acc_a};
        acc_b        = push_b && (free_after_a != 2'd0);
        drop_b       = push_b && !acc_b;

        beat_a = '{word: sh_bit, nbits: NB_W'(WORD_W), last: 1'b0, err: 1'b0};
        // Upper bits of sh_d are already clear, so the partial word is clean.
        beat_b = '{word: sh_d, nbits: cnt_d, last: 1'b1,
                   err: sticky_q | stuff_hit | drop_a};

        if (bus.in_eop) begin
            run_d    = '0;
            drop_d   = 1'b0;
            sh_d     = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q | stuff_hit | drop_a;
        end

        level_d = level_q + {1'b0, acc_a} + {1'b0, acc_b} - {1'b0, pop};
    end

    // Register bit-level state, queue contents and event pulses.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            run_q       <= '0;
            drop_q      <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            level_q     <= 2'd0;
            stuff_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            run_q       <= run_d;
            drop_q      <= drop_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            if (acc_a)
                mem_q[wr_ptr_q] <= beat_a;
            if (acc_b)
                mem_q[acc_a ? ~wr_ptr_q : wr_ptr_q] <= beat_b;
            wr_ptr_q    <= wr_ptr_q ^ (acc_a ^ acc_b);
            rd_ptr_q    <= rd_ptr_q ^ pop;
            level_q     <= level_d;
            stuff_err_q <= stuff_hit;
            overrun_q   <= drop_a | drop_b;
        end
    end

    // Present the queue head; fields read as zero when the queue is empty.
    always_comb begin
        head          = mem_q[rd_ptr_q];
        bus.out_valid = (level_q != 2'd0);
        bus.out_word  = bus.out_valid ? head.word  : '0;
        bus.out_nbits = bus.out_valid ? head.nbits : '0;
        bus.out_last  = bus.out_valid ? head.last  : 1'b0;
        bus.out_err   = bus.out_valid ? head.err   : 1'b0;
        bus.stuff_err = stuff_err_q;
        bus.overrun   = overrun_q;
    end
endmodule

// File: tb/tb_usb_unstuff_deser.sv
// Bench for usb_unstuff_deser: instance A (RUN_LEN=6, WORD_W=8) and
// instance B (RUN_LEN=3, WORD_W=4) sharing clock and reset.
module tb_usb_unstuff_deser;
    localparam int WA = 8 + 4 + 2;
    localparam int WB = 4 + 3 + 2;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    usb_unstuff_deser_if #(.WORD_W(8)) a_if ();
    usb_unstuff_deser_if #(.WORD_W(4)) b_if ();

    usb_unstuff_deser #(.RUN_LEN(6), .WORD_W(8)) dut_a (
        .clk  (clk),
        .nRST (nRST),
        .bus  (a_if.slave)
    );

    usb_unstuff_deser #(.RUN_LEN(3), .WORD_W(4)) dut_b (
        .clk  (clk),
        .nRST (nRST),
        .bus  (b_if.slave)
    );

    // ---------------- scoreboard ----------------
    logic [WA-1:0] exp_a [$];
    logic [WB-1:0] exp_b [$];
    int n_vec  = 0;
    int n_miss = 0;
    int stuff_a = 0, ovr_a = 0, stuff_b = 0, ovr_b = 0;
    logic [WA-1:0] prev_a;
    logic [WB-1:0] prev_b;
    logic hold_a = 1'b0, hold_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp_beat_a(input logic [31:0] w, input logic [31:0] nb, input logic l, input logic e);
        exp_a.push_back({w[7:0], nb[3:0], l, e});
    endtask

    task automatic exp_beat_b(input logic [31:0] w, input logic [31:0] nb, input logic l, input logic e);
        exp_b.push_back({w[3:0], nb[2:0], l, e});
    endtask

    // Monitor for A: pops on every transfer, counts pulses, checks hold stability.
    always @(negedge clk) begin
        logic [WA-1:0] cur;
        cur = {a_if.out_word, a_if.out_nbits, a_if.out_last, a_if.out_err};
        if (nRST) begin
            if (a_if.stuff_err) stuff_a++;
            if (a_if.overrun)   ovr_a++;
            if (a_if.out_valid && a_if.out_ready) begin
                if (exp_a.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL a_unexpected_beat: got 0x%0h, expected no beat", cur);
                end else begin
                    check("a_beat", 32'(cur), 32'(exp_a.pop_front()));
                end
            end
            if (a_if.out_valid && !a_if.out_ready) begin
                if (hold_a) check("a_head_stable", 32'(cur), 32'(prev_a));
                prev_a = cur;
                hold_a = 1'b1;
            end else begin
                hold_a = 1'b0;
            end
        end else begin
            hold_a = 1'b0;
        end
    end

    // Monitor for B.
    always @(negedge clk) begin
        logic [WB-1:0] cur;
        cur = {b_if.out_word, b_if.out_nbits, b_if.out_last, b_if.out_err};
        if (nRST) begin
            if (b_if.stuff_err) stuff_b++;
            if (b_if.overrun)   ovr_b++;
            if (b_if.out_valid && b_if.out_ready) begin
                if (exp_b.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL b_unexpected_beat: got 0x%0h, expected no beat", cur);
                end else begin
                    check("b_beat", 32'(cur), 32'(exp_b.pop_front()));
                end
            end
            if (b_if.out_valid && !b_if.out_ready) begin
                if (hold_b) check("b_head_stable", 32'(cur), 32'(prev_b));
                prev_b = cur;
                hold_b = 1'b1;
            end else begin
                hold_b = 1'b0;
            end
        end else begin
            hold_b = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_a(input logic b, input logic eop);
        a_if.in_bit = b; a_if.in_valid = 1'b1; a_if.in_eop = eop;
        @(posedge clk); #1;
        a_if.in_bit = 1'b0; a_if.in_valid = 1'b0; a_if.in_eop = 1'b0;
    endtask

    task automatic eop_a();
        a_if.in_eop = 1'b1;
        @(posedge clk); #1;
        a_if.in_eop = 1'b0;
    endtask

    task automatic send_b(input logic b, input logic eop);
        b_if.in_bit = b; b_if.in_valid = 1'b1; b_if.in_eop = eop;
        @(posedge clk); #1;
        b_if.in_bit = 1'b0; b_if.in_valid = 1'b0; b_if.in_eop = 1'b0;
    endtask

    task automatic eop_b();
        b_if.in_eop = 1'b1;
        @(posedge clk); #1;
        b_if.in_eop = 1'b0;
    endtask

    task automatic drain_a();
        int k;
        for (k = 0; k < 100 && exp_a.size() != 0; k++) begin
            @(posedge clk); #2;
        end
        if (exp_a.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL a_drain_timeout: %0d beats outstanding, expected 0", exp_a.size());
            exp_a.delete();
        end
        @(posedge clk); #2;
        check("a_queue_empty", 32'(a_if.out_valid), 32'd0);
    endtask

    task automatic drain_b();
        int k;
        for (k = 0; k < 100 && exp_b.size() != 0; k++) begin
            @(posedge clk); #2;
        end
        if (exp_b.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL b_drain_timeout: %0d beats outstanding, expected 0", exp_b.size());
            exp_b.delete();
        end
        @(posedge clk); #2;
        check("b_queue_empty", 32'(b_if.out_valid), 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] r;
        a_if.in_bit = 1'b0; a_if.in_valid = 1'b0; a_if.in_eop = 1'b0; a_if.out_ready = 1'b1;
        b_if.in_bit = 1'b0; b_if.in_valid = 1'b0; b_if.in_eop = 1'b0; b_if.out_ready = 1'b1;

        // Reset with live random input
        a_if.in_valid = 1'b1; b_if.in_valid = 1'b1;
        repeat (6) begin
            a_if.in_bit = 1'($urandom_range(0, 1));
            b_if.in_bit = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        @(negedge clk);
        check("a_reset_outputs", 32'({a_if.out_valid, a_if.out_word, a_if.out_nbits, a_if.out_last,
              a_if.out_err, a_if.stuff_err, a_if.overrun}), 32'd0);
        check("b_reset_outputs", 32'({b_if.out_valid, b_if.out_word, b_if.out_nbits, b_if.out_last,
              b_if.out_err, b_if.stuff_err, b_if.overrun}), 32'd0);
        @(posedge clk); #1;
        nRST = 1'b1;
        a_if.in_valid = 1'b0; b_if.in_valid = 1'b0;
        a_if.in_bit = 1'b0;   b_if.in_bit = 1'b0;

        // Five random bits: no beat until EOP, then a 5-bit last beat
        r = 5'($urandom_range(0, 31));
        for (int i = 0; i < 5; i++) send_a(r[i], 1'b0);
        @(posedge clk); #2;
        check("a_no_early_beat", 32'(a_if.out_valid), 32'd0);
        exp_beat_a(32'(r), 5, 1'b1, 1'b0);
        eop_a();
        drain_a();

        // Six ones, stuffed zero, two ones -> 0xFF full, then empty last beat
        exp_beat_a(32'hFF, 8, 1'b0, 1'b0);
        exp_beat_a(32'h00, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b0);
        send_a(1'b1, 1'b0);
        send_a(1'b1, 1'b0);
        eop_a();
        drain_a();
        check("a_stuff_count_clean", 32'(stuff_a), 32'd0);

        // Seven ones -> stuff error, last beat 0x3F/6 with err
        exp_beat_a(32'h3F, 6, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_a(1'b1, 1'b0);
        eop_a();
        drain_a();
        check("a_stuff_count_one", 32'(stuff_a), 32'd1);

        // Next packet clean: 1,0,1 -> 0x05/3
        exp_beat_a(32'h05, 3, 1'b1, 1'b0);
        send_a(1'b1, 1'b0); send_a(1'b0, 1'b0); send_a(1'b1, 1'b0);
        eop_a();
        drain_a();

        // Overrun: consumer stalled, third word and the last beat are dropped
        a_if.out_ready = 1'b0;
        exp_beat_a(32'h00, 8, 1'b0, 1'b0);
        exp_beat_a(32'h00, 8, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) send_a(1'b0, 1'b0);
        eop_a();
        repeat (3) @(posedge clk);
        #2;
        check("a_held_valid", 32'(a_if.out_valid), 32'd1);
        check("a_overrun_count_2", 32'(ovr_a), 32'd2);
        a_if.out_ready = 1'b1;
        drain_a();

        // Overrun mid-packet, EOP accepted later carries err
        a_if.out_ready = 1'b0;
        exp_beat_a(32'h00, 8, 1'b0, 1'b0);
        exp_beat_a(32'h00, 8, 1'b0, 1'b0);
        exp_beat_a(32'h07, 3, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) send_a(1'b0, 1'b0);
        a_if.out_ready = 1'b1;
        send_a(1'b1, 1'b0); send_a(1'b1, 1'b0); send_a(1'b1, 1'b0);
        eop_a();
        drain_a();
        check("a_overrun_count_3", 32'(ovr_a), 32'd3);

        // Bit completing a word together with EOP -> two beats
        exp_beat_a(32'h80, 8, 1'b0, 1'b0);
        exp_beat_a(32'h00, 0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_a(1'b0, 1'b0);
        send_a(1'b1, 1'b1);
        drain_a();

        // B: 1,1,1,(0 stuffed),1 with EOP -> 0xF/4 then empty last beat
        exp_beat_b(32'hF, 4, 1'b0, 1'b0);
        exp_beat_b(32'h0, 0, 1'b1, 1'b0);
        send_b(1'b1, 1'b0); send_b(1'b1, 1'b0); send_b(1'b1, 1'b0); send_b(1'b0, 1'b0);
        send_b(1'b1, 1'b1);
        drain_b();
        check("b_stuff_count_clean", 32'(stuff_b), 32'd0);

        // B: 1,1,1,(1 stuff error),0,1+EOP -> 0x7/4, then 0x1/1 with err
        exp_beat_b(32'h7, 4, 1'b0, 1'b0);
        exp_beat_b(32'h1, 1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_b(1'b1, 1'b0);
        send_b(1'b0, 1'b0);
        send_b(1'b1, 1'b1);
        drain_b();
        check("b_stuff_count_one", 32'(stuff_b), 32'd1);

        // B: reset mid-packet discards the partial word
        send_b(1'b1, 1'b0); send_b(1'b0, 1'b0);
        nRST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
        @(posedge clk); #2;
        check("b_no_beat_after_reset", 32'(b_if.out_valid), 32'd0);
        exp_beat_b(32'h0, 0, 1'b1, 1'b0);
        eop_b();
        drain_b();
        check("b_overrun_count", 32'(ovr_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
